div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to begin a division this cycle.
REQ-004 SHALL have port ALUControl, input, 3, op select; 3'b101 = signed divide, 3'b111 = unsigned divide, others = not a divide.
REQ-005 SHALL have port a, input, 32, dividend, sampled only on accept.
REQ-006 SHALL have port b, input, 32, divisor, sampled only on accept.
REQ-007 SHALL have port flush, input, 1, abort any in-flight division.
REQ-008 SHALL have port stall, output, 1, hold upstream pipeline stages.
REQ-009 SHALL have port busy, output, 1, division in progress.
REQ-010 SHALL have port done, output, 1, single-cycle result-valid pulse.
REQ-011 SHALL have port quotient, output, 32, registered quotient.
REQ-012 SHALL have port remainder, output, 32, registered remainder.
REQ-013 SHALL have port DivFlags, output, 4, {N, Z, C, V} of quotient.

Function
REQ-014 Accept SHALL occur when state is IDLE, start=1, ALUControl is 101 or 111, and flush=0; otherwise start is ignored.
REQ-015 States SHALL be IDLE, ITER, FIX, DONE.
REQ-016 IDLE->ITER on accept with b!=0: latch |a|, |b| for signed ops (raw values for unsigned), record the sign of a and the sign of a^b, and set the iteration counter to 31.
REQ-017 IDLE->DONE on accept with b==0: quotient=0, remainder=0, skipping ITER and FIX.
REQ-018 ITER SHALL perform one restoring shift-subtract step per cycle for 32 cycles, counter 31 down to 0; ITER->FIX when counter==0.
REQ-019 FIX SHALL negate the quotient if the sign of a^b is 1, and negate the remainder if a was negative (signed ops only); FIX->DONE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; a new accept is not possible in DONE.
REQ-021 Latency SHALL be 34 cycles from the accept edge to done for b!=0, and 1 cycle for b==0.
REQ-022 Signed results SHALL truncate toward zero; remainder takes the sign of the dividend.
REQ-023 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-024 quotient and remainder SHALL hold their last values until the next done; they are updated only when entering DONE.
REQ-025 DivFlags SHALL be N=quotient[31], Z=(quotient==0), C=0, V=0, valid while done=1.
REQ-026 busy SHALL be 1 in ITER and FIX, and 0 in IDLE and DONE.
REQ-027 stall SHALL be combinational: 1 when busy=1, or in IDLE on an accept cycle; 0 in DONE.
REQ-028 flush SHALL force the next state to IDLE from any state, with no done pulse and outputs unchanged; flush outranks start in the same cycle.
REQ-029 start asserted while busy=1 SHALL be ignored, with no queuing.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE, counter 0, quotient 0, remainder 0, busy 0, done 0, and DivFlags 4'b0100.
REQ-031 Reset asserted mid-division SHALL discard the operation; no done is issued after deassertion.
REQ-032 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-033 Shared package div_pkg SHALL hold the state enum, the ALU op constants ALU_SDIV=3'b101 and ALU_UDIV=3'b111, and DIV_W=32.
REQ-034 One combinational sub-module div_step SHALL implement a single restoring iteration: inputs {partial remainder, dividend bit, divisor}; outputs {next remainder, quotient bit}.
REQ-035 The block SHALL contain no combinational "/" or "%" operator.

Verification
REQ-036 Unsigned divide, a=100, b=7, start pulse -> done exactly 34 cycles later; quotient=14, remainder=2, stall high for 34 cycles.
REQ-037 Signed divide, a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, DivFlags N=1.
REQ-038 Signed divide, a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-039 Either op, b=0, a=123 -> done 1 cycle after accept; quotient=0, remainder=0, DivFlags Z=1.
REQ-040 Unsigned divide 100/7, then flush at ITER cycle 10 -> IDLE next cycle, no done; outputs keep their prior values; a new start is accepted the following cycle.
REQ-041 Second start asserted during ITER is ignored; reset_n pulsed low during ITER clears all outputs immediately, and no done follows.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

  localparam logic [2:0] ALU_SDIV = 3'b101;
  localparam logic [2:0] ALU_UDIV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] v);
    return ~v + DIV_W'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of a 32-bit unsigned divide.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] diff;

  // rem_in < divisor, so a set top bit of diff means the subtraction borrowed.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[DIV_W];
    rem_out = q_bit ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned 32-bit divider: IDLE -> ITER (32 steps) -> FIX -> DONE.
module div_seq
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic [3:0]       DivFlags,
  output div_state_e       dbg_state
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [DIV_W-1:0] quotient_q, quotient_d;
  logic [DIV_W-1:0] remainder_q, remainder_d;

  logic             is_div, is_signed, accept;
  logic [DIV_W-1:0] step_rem;
  logic             step_q;

  div_step u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[DIV_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Handshake: a request is taken in the cycle start=1 with a divide op while
  // IDLE and not flushed; stall rises in that same cycle. There is no queuing.
  always_comb begin
    is_div    = (ALUControl == ALU_SDIV) || (ALUControl == ALU_UDIV);
    is_signed = (ALUControl == ALU_SDIV);
    accept    = (state_q == S_IDLE) && start && is_div && !flush;

    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (b == '0) begin
            state_d     = S_DONE;
            quotient_d  = '0;
            remainder_d = '0;
          end else begin
            state_d = S_ITER;
            dvd_d   = (is_signed && a[DIV_W-1]) ? neg_w(a) : a;
            dvs_d   = (is_signed && b[DIV_W-1]) ? neg_w(b) : b;
            rem_d   = '0;
            neg_q_d = is_signed && (a[DIV_W-1] ^ b[DIV_W-1]);
            neg_r_d = is_signed && a[DIV_W-1];
            cnt_d   = CNT_MAX;
          end
        end
      end
      S_ITER: begin
        // Dividend shifts out the top while quotient bits shift in at the bottom.
        rem_d = step_rem;
        dvd_d = {dvd_q[DIV_W-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        state_d     = S_DONE;
        quotient_d  = neg_q_q ? neg_w(dvd_q) : dvd_q;
        remainder_d = neg_r_q ? neg_w(rem_q) : rem_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d     = S_IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    busy      = (state_q == S_ITER) || (state_q == S_FIX);
    done      = (state_q == S_DONE);
    stall     = busy || accept;
    quotient  = quotient_q;
    remainder = remainder_q;
    DivFlags  = {quotient_q[DIV_W-1], (quotient_q == '0), 1'b0, 1'b0};
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus flush, re-start and reset sequences.
module tb_div_seq;
  import div_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  alu_ctl;
  logic [31:0] a_i, b_i;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] quotient, remainder;
  logic [3:0]  div_flags;
  div_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  div_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ALUControl (alu_ctl),
    .a          (a_i),
    .b          (b_i),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .DivFlags   (div_flags),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          stl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT IDLE; drives the request at once.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stl);
    bit seen;
    start = 1'b1; alu_ctl = op; a_i = a; b_i = b;
    #1;
    stl = stall ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
      @(negedge clk);
      if (stall) stl++;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int lat, stl, done_cnt;
    bit seen;

    vecs[0]  = '{ALU_UDIV, 32'd100,        32'd7,          32'd14,         32'd2,          4'b0000, 34, 34};
    vecs[1]  = '{ALU_SDIV, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   4'b1000, 34, 34};
    vecs[2]  = '{ALU_SDIV, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          4'b1000, 34, 34};
    vecs[3]  = '{ALU_UDIV, 32'd123,        32'd0,          32'd0,          32'd0,          4'b0100, 1,  1};
    vecs[4]  = '{ALU_UDIV, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          4'b1000, 34, 34};
    vecs[5]  = '{ALU_SDIV, 32'd123,        32'd0,          32'd0,          32'd0,          4'b0100, 1,  1};
    vecs[6]  = '{ALU_SDIV, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          4'b1000, 34, 34};
    vecs[7]  = '{ALU_SDIV, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   4'b0000, 34, 34};
    vecs[8]  = '{ALU_UDIV, 32'd5,          32'd10,         32'd0,          32'd5,          4'b0100, 34, 34};
    vecs[9]  = '{ALU_UDIV, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   4'b0100, 34, 34};
    vecs[10] = '{ALU_SDIV, 32'd100,        32'd7,          32'd14,         32'd2,          4'b0000, 34, 34};
    vecs[11] = '{ALU_UDIV, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          4'b0000, 34, 34};

    // Reset block
    reset_n = 1'b0; start = 1'b0; alu_ctl = 3'b000; a_i = '0; b_i = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_flags", 32'(div_flags), 32'h4);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    reset_n = 1'b1;

    // Table vectors; the first is accepted on the first edge after reset release.
    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].op, vecs[i].a, vecs[i].b, lat, stl);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_stall_cycles", i), 32'(stl), 32'(vecs[i].stl));
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_flags", i), 32'(div_flags), 32'(vecs[i].f));
      @(negedge clk);
      check($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
    end

    // Non-divide op with start must be ignored.
    start = 1'b1; alu_ctl = 3'b010; a_i = 32'd9; b_i = 32'd3;
    #1 check("nodiv_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("nodiv_state", 32'(dbg_state), 32'(S_IDLE));
    check("nodiv_busy", 32'(busy), 32'd0);

    // Flush during ITER: back to IDLE, outputs keep vector 11 results.
    start = 1'b1; alu_ctl = ALU_UDIV; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(dbg_state), 32'(S_IDLE));
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_quotient_kept", quotient, 32'h7FFFFFFC);
    check("flush_remainder_kept", remainder, 32'd1);
    run_div(ALU_SDIV, 32'hFFFFFFF9, 32'd2, lat, stl);
    check("post_flush_latency", 32'(lat), 32'd34);
    check("post_flush_quotient", quotient, 32'hFFFFFFFD);
    check("post_flush_remainder", remainder, 32'hFFFFFFFF);
    @(negedge clk);

    // A second start during ITER (a b==0 request) must not be taken.
    start = 1'b1; alu_ctl = ALU_UDIV; a_i = 32'd100; b_i = 32'd7;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (lat == 5) begin
        start = 1'b1; alu_ctl = ALU_SDIV; a_i = 32'd123; b_i = 32'd0;
      end
    end
    check("restart_latency", 32'(lat), 32'd34);
    check("restart_quotient", quotient, 32'd14);
    check("restart_remainder", remainder, 32'd2);
    @(negedge clk);

    // Reset mid-ITER clears outputs at once and no done follows.
    start = 1'b1; alu_ctl = ALU_UDIV; a_i = 32'hFFFFFFFF; b_i = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_flags", 32'(div_flags), 32'h4);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_div(ALU_SDIV, 32'h80000000, 32'hFFFFFFFF, lat, stl);
    check("post_rst_latency", 32'(lat), 32'd34);
    check("post_rst_quotient", quotient, 32'h80000000);
    check("post_rst_remainder", remainder, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
